// File: rtl/fp_norm_pack.sv
// rtl/fp_norm_pack.sv - iterative normaliser and IEEE-754 single-precision packer
// One left shift per NORM cycle; overflow saturates to +/-inf, underflow flushes to signed zero.
`timescale 1ns/1ps
module fp_norm_pack #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FRAC_W+1:0]       mag,
  input  logic                    sign,
  input  logic [EXP_W-1:0]        exp_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    zero
);

  localparam int MAG_W = FRAC_W + 2;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_DONE} state_t;

  state_t                  r_state;
  logic [MAG_W-1:0]        r_mag;
  logic [EXP_W-1:0]        r_exp;
  logic                    r_sign;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic [EXP_W+FRAC_W:0]   r_result;
  logic                    r_overflow;
  logic                    r_underflow;
  logic                    r_zero;

  logic [EXP_W-1:0]        w_exp_inc;
  logic [EXP_W+FRAC_W:0]   w_ovf_res;
  logic [EXP_W+FRAC_W:0]   w_unf_res;

  assign w_exp_inc = r_exp + EXP_ONE;
  assign w_ovf_res = {r_sign, EXP_MAX, {FRAC_W{1'b0}}};
  assign w_unf_res = {r_sign, {(EXP_W+FRAC_W){1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mag       <= '0;
      r_exp       <= '0;
      r_sign      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mag      <= mag;
            r_sign     <= sign;
            r_exp      <= exp_in;
            r_in_ready <= 1'b0;
            r_state    <= S_NORM;
          end
        end
        S_NORM: begin
          // Every branch except the shift completes the transaction.
          if (r_mag == '0) begin
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (r_exp == EXP_MAX) begin
            r_result    <= w_ovf_res;
            r_overflow  <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (r_exp == '0) begin
            r_result    <= w_unf_res;
            r_underflow <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (r_mag[MAG_W-1]) begin
            if (w_exp_inc == EXP_MAX) begin
              r_result   <= w_ovf_res;
              r_overflow <= 1'b1;
            end else begin
              r_result <= {r_sign, w_exp_inc, r_mag[FRAC_W:1]};
            end
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (r_mag[MAG_W-2]) begin
            r_result    <= {r_sign, r_exp, r_mag[FRAC_W-1:0]};
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (r_exp <= EXP_ONE) begin
            r_result    <= w_unf_res;
            r_underflow <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_mag <= {r_mag[MAG_W-2:0], 1'b0};
            r_exp <= r_exp - EXP_ONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_zero      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign zero      = r_zero;

endmodule

// File: tb/tb_fp_norm_pack.sv
// tb/tb_fp_norm_pack.sv - self-checking bench for fp_norm_pack
// Directed cases followed by randomized operands against a closed-form reference model.
`timescale 1ns/1ps
module tb_fp_norm_pack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [24:0] mag = '0;
  logic        sign = 1'b0;
  logic [7:0]  exp_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        zero;

  int n_checks = 0;
  int n_errors = 0;

  fp_norm_pack #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mag(mag), .sign(sign), .exp_in(exp_in), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .overflow(overflow),
    .underflow(underflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: find the leading one, derive shift count and final exponent directly.
  function automatic void model(input logic [24:0] m, input logic s, input int e,
                                output logic [31:0] r, output logic [2:0] f, output int k);
    int p;
    int sh;
    logic [24:0] mm;
    r = 32'h0; f = 3'b000; k = 0; p = -1;
    for (int i = 0; i < 25; i++) if (m[i]) p = i;
    if (p < 0) begin
      r = 32'h0; f = 3'b001;
    end else if (e == 255) begin
      r = {s, 8'hFF, 23'h0}; f = 3'b100;
    end else if (e == 0) begin
      r = {s, 31'h0}; f = 3'b010;
    end else if (p == 24) begin
      if (e + 1 == 255) begin
        r = {s, 8'hFF, 23'h0}; f = 3'b100;
      end else begin
        r = {s, 8'(e + 1), m[23:1]};
      end
    end else begin
      sh = 23 - p;
      if (e - sh >= 1) begin
        mm = m << sh;
        r = {s, 8'(e - sh), mm[22:0]};
        k = sh;
      end else begin
        r = {s, 31'h0}; f = 3'b010;
        k = e - 1;
      end
    end
  endfunction

  task automatic run_txn(input string tag, input logic [24:0] m, input logic s,
                         input logic [7:0] e, input int hold, input bit noise);
    logic [31:0] er;
    logic [2:0]  ef;
    int          ek;
    int          cyc;
    bit          rdy_bad;
    logic [31:0] held;
    model(m, s, int'(e), er, ef, ek);
    @(negedge clk);
    chk({tag, "/in_ready_idle"}, 32'(in_ready), 32'd1);
    mag = m; sign = s; exp_in = e; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0; rdy_bad = 0;
    while (!out_valid && cyc < 40) begin
      if (noise) begin
        in_valid = 1'b1; mag = 25'($urandom); sign = 1'($urandom); exp_in = 8'($urandom);
      end
      if (in_ready) rdy_bad = 1;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk({tag, "/latency"}, 32'(cyc), 32'(ek + 1));
    chk({tag, "/result"}, result, er);
    chk({tag, "/flags"}, {29'h0, overflow, underflow, zero}, {29'h0, ef});
    chk({tag, "/busy_ready"}, 32'(rdy_bad), 32'd0);
    held = result; rdy_bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (in_ready || !out_valid || result !== held) rdy_bad = 1;
    end
    if (hold > 0) chk({tag, "/hold"}, 32'(rdy_bad), 32'd0);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "/post_hs"}, {28'h0, out_valid, overflow, underflow, zero}, 32'h0);
    chk({tag, "/post_hs_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [24:0] rm;
    logic [7:0]  re;
    int          pos;
    int          sel;
    repeat (3) @(posedge clk);
    #1;
    chk("reset/out", {28'h0, out_valid, overflow, underflow, zero}, 32'h0);
    chk("reset/in_ready", 32'(in_ready), 32'd1);
    chk("reset/result", result, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    run_txn("case1", 25'h0800000, 1'b0, 8'd127, 0, 0);
    run_txn("case2", 25'h1000000, 1'b1, 8'd127, 0, 0);
    run_txn("case3", 25'h0000001, 1'b0, 8'd127, 0, 1);
    run_txn("case4_zero", 25'h0000000, 1'b1, 8'd90, 0, 0);
    run_txn("case4_ovf", 25'h1000000, 1'b0, 8'd254, 0, 0);
    run_txn("case5_unf", 25'h0000004, 1'b1, 8'd5, 0, 0);
    run_txn("case6_hold", 25'h0800000, 1'b0, 8'd127, 5, 0);
    run_txn("exp255", 25'h0800000, 1'b1, 8'd255, 0, 0);
    run_txn("exp0", 25'h0800000, 1'b0, 8'd0, 0, 0);

    // Reset in the middle of a long normalisation.
    @(negedge clk);
    mag = 25'h0000001; sign = 1'b0; exp_in = 8'd127; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("midreset/out", {28'h0, out_valid, overflow, underflow, zero}, 32'h0);
    chk("midreset/in_ready", 32'(in_ready), 32'd1);
    chk("midreset/result", result, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    run_txn("after_reset", 25'h0800000, 1'b0, 8'd127, 0, 0);

    for (int t = 0; t < 40; t++) begin
      pos = int'($urandom_range(0, 25));
      if (pos == 25) rm = '0;
      else begin
        rm = 25'($urandom) & ((25'd1 << pos) - 25'd1);
        rm = rm | (25'd1 << pos);
      end
      sel = int'($urandom_range(0, 7));
      case (sel)
        0: re = 8'd0;
        1: re = 8'd1;
        2: re = 8'd254;
        3: re = 8'd255;
        4: re = 8'($urandom_range(2, 24));
        default: re = 8'($urandom);
      endcase
      run_txn("rand", rm, 1'($urandom), re, int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
